pc_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of branch_calculator: consumes its BTA plus the jump target, holds the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. Owns next-PC selection, stall hold, wrong-path flush, and latching of redirects that resolve while the pipeline is stalled.

---
 rtl/pc_fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_pc_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Instruction-fetch stage fed by branch_calculator. Holds the program
//   counter, drives the instruction-memory address and registers the fetched
//   instruction into the IF/ID pipeline register. Handles next-PC selection
//   (jump > branch_taken > latched redirect > pc+4), stall hold, wrong-path
//   flush, and latching of redirects that resolve while the pipeline is
//   stalled.
//
//   Optional macro PC_REDIRECT_CNT_EN: when defined, redirect_count is a
//   saturating counter of applied redirects. When undefined, no counter
//   register exists and redirect_count is tied to zero.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID this cycle
//   branch_taken, bta branch redirect and its target
//   jump, jump_target jump redirect and its target
//   imem_instr        combinational instruction-memory data at pc
//   pc, pc_plus_4     current fetch address and its successor
//   ifid_instr, ifid_pc_plus_4, ifid_valid   IF/ID pipeline register
//   redirect_pending  a redirect is latched awaiting stall release
//   misalign_err      sticky flag: a selected target had bits[1:0] != 0
//   redirect_count    applied-redirect count (zero when feature disabled)
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      bta,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus_4,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc_plus_4,
  output logic             ifid_valid,
  output logic             redirect_pending,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t              state_p0;
  state_t              state_nxt;
  logic [DATA_W-1:0]   pc_p0;
  logic [DATA_W-1:0]   pend_target_p0;
  logic                misalign_p0;
  logic [DATA_W-1:0]   ifid_instr_p1;
  logic [DATA_W-1:0]   ifid_pc_plus_4_p1;
  logic                vld_p1;

  logic                fresh_redirect;
  logic                redirect_apply;
  logic [DATA_W-1:0]   raw_target;
  logic [DATA_W-1:0]   clean_target;
  logic [DATA_W-1:0]   next_pc;

  function automatic logic [DATA_W-1:0] sanitize_target(input logic [DATA_W-1:0] t);
    return {t[DATA_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [DATA_W-1:0] t);
    return |t[1:0];
  endfunction

  // ---- Stage p0: next-PC selection ----
  always_comb begin
    fresh_redirect = jump | branch_taken;
    raw_target     = jump ? jump_target : bta;
    clean_target   = sanitize_target(raw_target);
    redirect_apply = !stall && (fresh_redirect || (state_p0 == PENDING));
    next_pc        = pc_p0 + 32'd4;
    if (fresh_redirect) begin
      next_pc = clean_target;
    end else if (state_p0 == PENDING) begin
      next_pc = pend_target_p0;
    end
  end

  // A stall with a fresh redirect latches it; any unstalled edge consumes or
  // discards the pending one (a fresh redirect on release takes priority).
  always_comb begin
    state_nxt = state_p0;
    if (!stall) begin
      state_nxt = IDLE;
    end else if (fresh_redirect) begin
      state_nxt = PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= IDLE;
      pend_target_p0 <= '0;
      pc_p0          <= RESET_PC;
      misalign_p0    <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      if (stall && fresh_redirect) begin
        pend_target_p0 <= clean_target;
      end
      if (!stall) begin
        pc_p0 <= next_pc;
      end
      if (fresh_redirect && is_misaligned(raw_target)) begin
        misalign_p0 <= 1'b1;
      end
    end
  end

  // ---- Stage p1: IF/ID register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_p1     <= '0;
      ifid_pc_plus_4_p1 <= '0;
      vld_p1            <= 1'b0;
    end else if (!stall) begin
      if (redirect_apply) begin
        ifid_instr_p1     <= '0;
        ifid_pc_plus_4_p1 <= '0;
        vld_p1            <= 1'b0;
      end else begin
        ifid_instr_p1     <= imem_instr;
        ifid_pc_plus_4_p1 <= pc_p0 + 32'd4;
        vld_p1            <= 1'b1;
      end
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [CNT_W-1:0] redirect_cnt_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_p0 <= '0;
    end else if (redirect_apply && (redirect_cnt_p0 != '1)) begin
      redirect_cnt_p0 <= redirect_cnt_p0 + 1'b1;
    end
  end

  assign redirect_count = redirect_cnt_p0;
`else
  assign redirect_count = '0;
`endif

  assign pc               = pc_p0;
  assign pc_plus_4        = pc_p0 + 32'd4;
  assign ifid_instr       = ifid_instr_p1;
  assign ifid_pc_plus_4   = ifid_pc_plus_4_p1;
  assign ifid_valid       = vld_p1;
  assign redirect_pending = (state_p0 == PENDING);
  assign misalign_err     = misalign_p0;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural reference model.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump;
  logic [31:0] bta, jump_target, imem_instr;
  logic [31:0] pc, pc_plus_4, ifid_instr, ifid_pc_plus_4;
  logic        ifid_valid, redirect_pending, misalign_err;
  logic [31:0] redirect_count;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [31:0] m_pc, m_ifid_instr, m_ifid_pc4, m_pend_t, m_cnt;
  logic        m_valid, m_pend, m_mis;

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .bta              (bta),
    .jump             (jump),
    .jump_target      (jump_target),
    .imem_instr       (imem_instr),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .ifid_instr       (ifid_instr),
    .ifid_pc_plus_4   (ifid_pc_plus_4),
    .ifid_valid       (ifid_valid),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err),
    .redirect_count   (redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the fetch stage expressed with the plain rules:
  // reset wins, otherwise pick the highest-priority redirect or pc+4.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        fresh;
    if (rst) begin
      m_pc = 32'h0; m_ifid_instr = 0; m_ifid_pc4 = 0; m_valid = 0;
      m_pend = 0; m_pend_t = 0; m_mis = 0; m_cnt = 0;
      return;
    end
    fresh = jump || branch_taken;
    tgt   = jump ? jump_target : bta;
    if (fresh && (tgt % 4 != 0)) m_mis = 1;
    tgt = tgt - (tgt % 4);
    if (stall) begin
      if (fresh) begin
        m_pend   = 1;
        m_pend_t = tgt;
      end
    end else begin
      if (fresh || m_pend) begin
        m_pc = fresh ? tgt : m_pend_t;
        m_ifid_instr = 0; m_ifid_pc4 = 0; m_valid = 0;
`ifdef PC_REDIRECT_CNT_EN
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      end else begin
        m_ifid_instr = imem_instr;
        m_ifid_pc4   = m_pc + 4;
        m_valid      = 1;
        m_pc         = m_pc + 4;
      end
      m_pend = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},       pc,               m_pc);
    chk({tag, "_pc4"},      pc_plus_4,        m_pc + 32'd4);
    chk({tag, "_instr"},    ifid_instr,       m_ifid_instr);
    chk({tag, "_ifpc4"},    ifid_pc_plus_4,   m_ifid_pc4);
    chk({tag, "_valid"},    {31'b0, ifid_valid},       {31'b0, m_valid});
    chk({tag, "_pending"},  {31'b0, redirect_pending}, {31'b0, m_pend});
    chk({tag, "_misalign"}, {31'b0, misalign_err},     {31'b0, m_mis});
    chk({tag, "_count"},    redirect_count,   m_cnt);
  endtask

  task automatic step(input string tag, input logic r, input logic s,
                      input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt,
                      input logic [31:0] ins);
    rst = r; stall = s; jump = j; jump_target = jt;
    branch_taken = b; bta = bt; imem_instr = ins;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic        r_r, r_s, r_j, r_b;
    logic [31:0] r_jt, r_bt;

    m_pc = 0; m_ifid_instr = 0; m_ifid_pc4 = 0; m_pend_t = 0; m_cnt = 0;
    m_valid = 0; m_pend = 0; m_mis = 0;

    // 1: reset then sequential fetch
    step("rst", 1, 0, 0, 0, 0, 0, 32'h1111_1111);
    chk("rst_pc_const", pc, 32'h0);
    for (int i = 0; i < 3; i++) step("seq", 0, 0, 0, 0, 0, 0, 32'h1111_1111);
    chk("seq_pc_const", pc, 32'h0000_000C);
    chk("seq_ifpc4_const", ifid_pc_plus_4, 32'h0000_000C);

    // 2: taken branch, one bubble, then valid fetch from target
    step("j1000", 0, 0, 1, 32'h1000_0000, 0, 0, 32'h2222_2222);
    step("br", 0, 0, 0, 0, 1, 32'h1000_0008, 32'h3333_3333);
    chk("br_pc_const", pc, 32'h1000_0008);
    step("brnext", 0, 0, 0, 0, 0, 0, 32'h4444_4444);
    chk("brnext_ifpc4_const", ifid_pc_plus_4, 32'h1000_000C);

    // 3: jump beats branch in the same cycle
    step("jprio", 0, 0, 1, 32'h0040_0000, 1, 32'h1000_0008, 32'h5555_5555);
    chk("jprio_pc_const", pc, 32'h0040_0000);

    // 4: redirect latched under stall, applied on release
    step("st0", 0, 1, 0, 0, 1, 32'h20, 32'h6666_6666);
    step("st1", 0, 1, 0, 0, 0, 0, 32'h7777_7777);
    step("st2", 0, 1, 0, 0, 0, 0, 32'h8888_8888);
    chk("st_pending_const", {31'b0, redirect_pending}, 32'h1);
    step("rel", 0, 0, 0, 0, 0, 0, 32'h9999_9999);
    chk("rel_pc_const", pc, 32'h20);

    // 5: misaligned jump target, sticky flag
    step("mis", 0, 0, 1, 32'h13, 0, 0, 32'hAAAA_AAAA);
    chk("mis_pc_const", pc, 32'h10);
    step("mis1", 0, 0, 0, 0, 0, 0, 32'hBBBB_BBBB);
    step("mis2", 0, 0, 0, 0, 0, 0, 32'hCCCC_CCCC);

    // 6: PC wrap, then reset while pending
    step("wrapj", 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    step("wrap", 0, 0, 0, 0, 0, 0, 32'hDDDD_DDDD);
    chk("wrap_pc_const", pc, 32'h0);
    step("pend", 0, 1, 1, 32'h0000_0400, 0, 0, 32'h0);
    step("rstpend", 1, 1, 0, 0, 0, 0, 32'h0);
    chk("rstpend_pending_const", {31'b0, redirect_pending}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_r  = ($urandom_range(0, 99) < 3);
      r_s  = ($urandom_range(0, 99) < 30);
      r_j  = ($urandom_range(0, 99) < 10);
      r_b  = ($urandom_range(0, 99) < 15);
      r_jt = $urandom;
      r_bt = $urandom;
      if ($urandom_range(0, 3) != 0) r_jt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) r_bt[1:0] = 2'b00;
      step("rnd", r_r, r_s, r_j, r_jt, r_b, r_bt, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
